// File: rtl/image_byte_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | image_byte_streamer: snapshots a packed image and streams it out one byte |
// | per valid/ready transfer, byte 0 first, then pulses done.  Rev 1.0        |
// +--------------------------------------------------------------------------+
module image_byte_streamer #(
  parameter int IMG_BYTES  = 113,
  parameter int TOTAL_BITS = 904
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [TOTAL_BITS-1:0] img_in,
  output logic [7:0]            dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  busy,
  output logic                  done,
  output logic [6:0]            byte_index
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [6:0] LAST_IDX = 7'(IMG_BYTES - 1);

  state_t                state_q, state_d;
  logic [6:0]            index_q, index_d;
  logic [TOTAL_BITS-1:0] shadow_q, shadow_d;
  logic                  xfer;
  logic [9:0]            bit_offset;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  // The shadow needs no reset: it is only read in SEND, which always follows a capture.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    shadow_d = shadow_q;
    xfer     = (state_q == ST_SEND) && dout_ready;
    if (abort) begin
      state_d = ST_IDLE;
      index_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            shadow_d = img_in;
            index_d  = '0;
            state_d  = ST_SEND;
          end
        end
        ST_SEND: begin
          if (xfer) begin
            if (index_q == LAST_IDX) begin
              state_d = ST_DONE;
            end else begin
              index_d = index_q + 7'd1;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          index_d = '0;
        end
        default: begin
          state_d = ST_IDLE;
          index_d = '0;
        end
      endcase
    end
  end

  // Outputs depend only on registered state, index and shadow; dout_ready never reaches them.
  always_comb begin
    bit_offset = {index_q, 3'b000};
    dout_valid = (state_q == ST_SEND);
    dout       = dout_valid ? shadow_q[bit_offset +: 8] : 8'h00;
    busy       = (state_q == ST_SEND) || (state_q == ST_DONE);
    done       = (state_q == ST_DONE);
    byte_index = index_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_image_byte_streamer.sv
`default_nettype none
// Scoreboard bench for image_byte_streamer: a driver issues scenarios and queues
// the expected byte sequence; a negedge monitor pops and compares transfers.
module tb_image_byte_streamer;

  localparam int NB = 113;
  localparam int TB = 904;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [TB-1:0] img_in = '0;
  logic [7:0]    dout;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic          busy;
  logic          done;
  logic [6:0]    byte_index;

  image_byte_streamer #(.IMG_BYTES(NB), .TOTAL_BITS(TB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .img_in     (img_in),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .done       (done),
    .byte_index (byte_index)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] idx;
    logic [7:0] data;
    bit         last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   expect_done = 0;
  bit   stalled_prev = 0;
  logic [7:0] prev_dout;
  logic [6:0] prev_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: a captured image simply becomes its bytes, in ascending order.
  task automatic push_image(input logic [TB-1:0] img);
    for (int k = 0; k < NB; k++) begin
      exp_t e;
      e.idx  = 7'(k);
      e.data = img[k*8 +: 8];
      e.last = (k == NB - 1);
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [TB-1:0] rand_img();
    logic [TB-1:0] img;
    for (int k = 0; k < NB; k++) img[k*8 +: 8] = 8'($urandom);
    return img;
  endfunction

  task automatic flush_model();
    exp_q.delete();
    expect_done  = 0;
    stalled_prev = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      bit got_last;
      got_last = 0;
      if (dout_valid) begin
        if (stalled_prev) begin
          chk("stall_dout_hold", 32'(dout), 32'(prev_dout));
          chk("stall_index_hold", 32'(byte_index), 32'(prev_idx));
        end
        if (dout_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_transfer", 32'(1), 32'(0));
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("xfer_data", 32'(dout), 32'(e.data));
            chk("xfer_index", 32'(byte_index), 32'(e.idx));
            got_last = e.last;
          end
          stalled_prev = 0;
        end else begin
          stalled_prev = 1;
          prev_dout    = dout;
          prev_idx     = byte_index;
        end
      end else begin
        stalled_prev = 0;
        chk("dout_zero_when_invalid", 32'(dout), 32'(0));
      end
      if (done || expect_done) chk("done_pulse", 32'(done), 32'(expect_done));
      expect_done = got_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_stream(input logic [TB-1:0] img);
    start  = 1'b1;
    img_in = img;
    tick();
    start = 1'b0;
    push_image(img);
    chk("first_valid", 32'(dout_valid), 32'(1));
    chk("first_index", 32'(byte_index), 32'(0));
    chk("first_byte", 32'(dout), 32'(img[7:0]));
  endtask

  task automatic wait_idle(input bit rnd_ready, input bit rnd_img);
    bit idle_seen;
    idle_seen = 0;
    for (int c = 0; c < 2000; c++) begin
      if (!busy) begin
        idle_seen = 1;
        break;
      end
      if (rnd_ready) dout_ready = 1'($urandom_range(0, 1));
      if (rnd_img) img_in = rand_img();
      tick();
    end
    chk("idle_reached", 32'(idle_seen), 32'(1));
    chk("all_bytes_sent", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic wait_index(input logic [6:0] target, input bit rnd_ready);
    bit found;
    found = 0;
    for (int c = 0; c < 2000; c++) begin
      if (dout_valid && byte_index == target) begin
        found = 1;
        break;
      end
      if (rnd_ready) dout_ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("index_reached", 32'(found), 32'(1));
  endtask

  initial begin
    logic [TB-1:0] img_a, img_b;

    // Reset and idle
    repeat (3) tick();
    chk("reset_dout", 32'(dout), 32'(0));
    chk("reset_valid", 32'(dout_valid), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_index", 32'(byte_index), 32'(0));
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_busy", 32'(busy), 32'(0));
    end

    // Full stream with ready high, cycle-exact
    for (int k = 0; k < NB; k++) img_a[k*8 +: 8] = 8'(k);
    dout_ready = 1'b1;
    start_stream(img_a);
    repeat (NB - 1) tick();
    chk("last_byte_cycle_valid", 32'(dout_valid), 32'(1));
    chk("last_byte_cycle_index", 32'(byte_index), 32'(NB - 1));
    chk("last_byte_cycle_data", 32'(dout), 32'(8'h70));
    tick();
    chk("done_cycle_done", 32'(done), 32'(1));
    chk("done_cycle_valid", 32'(dout_valid), 32'(0));
    chk("done_cycle_busy", 32'(busy), 32'(1));
    tick();
    chk("after_done_busy", 32'(busy), 32'(0));
    chk("after_done_done", 32'(done), 32'(0));

    // Earliest restart, random backpressure, img_in churning every cycle
    start_stream(rand_img());
    wait_idle(1'b1, 1'b1);

    // Start while busy is ignored
    dout_ready = 1'b1;
    img_a = rand_img();
    img_b = ~img_a;
    start_stream(img_a);
    wait_index(7'd40, 1'b0);
    start  = 1'b1;
    img_in = img_b;
    tick();
    start = 1'b0;
    wait_idle(1'b0, 1'b0);

    // Abort while stalled at byte 57
    start_stream(rand_img());
    wait_index(7'd57, 1'b1);
    dout_ready = 1'b0;
    abort      = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 32'(dout_valid), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_index", 32'(byte_index), 32'(0));
    exp_q.delete();
    repeat (4) tick();
    chk("abort_no_done_busy", 32'(busy), 32'(0));
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_start_together_busy", 32'(busy), 32'(0));
    dout_ready = 1'b1;
    start_stream(rand_img());
    wait_idle(1'b1, 1'b0);

    // Asynchronous reset mid-stream at byte 100
    dout_ready = 1'b1;
    start_stream(rand_img());
    wait_index(7'd100, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_dout", 32'(dout), 32'(0));
    chk("async_rst_valid", 32'(dout_valid), 32'(0));
    chk("async_rst_busy", 32'(busy), 32'(0));
    chk("async_rst_done", 32'(done), 32'(0));
    chk("async_rst_index", 32'(byte_index), 32'(0));
    flush_model();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    start_stream(rand_img());
    wait_idle(1'b1, 1'b1);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
